apb_slave_regs: RTL and testbench
=================================

APB_SLAVE_REGS -- requirements
Module: apb_slave_regs

Interface
REQ-001 Parameter WAIT_CYCLES, default 1, access-phase wait states inserted before PREADY; legal range 0..15.
REQ-002 Parameter NUM_REGS, default 16, number of 32-bit word registers; legal range 2..64.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 psel  input  1  APB select from requester.
REQ-006 penable  input  1  APB enable; marks ACCESS phase.
REQ-007 pwrite  input  1  1 = write, 0 = read.
REQ-008 paddr  input  8  byte address.
REQ-009 pwdata  input  32  write data.
REQ-010 prdata  output  32  read data.
REQ-011 pready  output  1  transfer complete.
REQ-012 pslverr  output  1  transfer error, valid only with pready.

Function
REQ-013 Register map: word index = paddr[7:2]; reg 0 = read-only ID, constant 32'hA5B2_0001; regs 1..NUM_REGS-1 read/write.
REQ-014 States: IDLE, ACCESS; SETUP is the IDLE cycle in which psel=1, penable=0 is sampled.
REQ-015 IDLE -> ACCESS on an edge sampling psel=1, penable=0; on that edge capture pwrite, word index, error flag, selected register value, and load wait counter with WAIT_CYCLES.
REQ-016 Error flag set at SETUP when paddr[1:0] != 0, or word index >= NUM_REGS, or pwrite=1 to reg 0.
REQ-017 In ACCESS, each edge with psel=1, penable=1, counter != 0 decrements counter by 1.
REQ-018 pready = (state == ACCESS) and psel and penable and counter == 0; combinational, never high outside ACCESS phase.
REQ-019 Latency: WAIT_CYCLES=0 -> pready high in first ACCESS cycle; WAIT_CYCLES=N -> pready high in ACCESS cycle N+1.
REQ-020 pslverr = pready and captured error flag; otherwise 0.
REQ-021 prdata = captured register value when pready=1, captured pwrite=0, error flag=0; otherwise 32'h0.
REQ-022 Write commits on the edge where pready=1, captured pwrite=1, error flag=0: reg[word index] <= pwdata; no other write path.
REQ-023 Erroring transfer changes no register.
REQ-024 ACCESS -> IDLE on the edge where pready=1; if psel=1, penable=0 sampled on the following edge, new SETUP accepted (back-to-back, one IDLE-state cycle).
REQ-025 Abort: psel=0 sampled in ACCESS before pready -> IDLE, no write, no response.
REQ-026 penable=1 sampled in IDLE without preceding SETUP: ignored, stay IDLE, pready=0.
REQ-027 psel=1, penable=0 sampled in ACCESS (requester restarted SETUP): treated as new SETUP, previous transfer discarded, no write.
REQ-028 paddr, pwrite changes during ACCESS have no effect; captured values used.
REQ-029 Read of reg 0 returns ID value regardless of earlier writes to reg 0.

Reset
REQ-030 rst_n=0 forces immediately: state IDLE, counter 0, regs 1..NUM_REGS-1 = 32'h0, pready=0, pslverr=0, prdata=32'h0.
REQ-031 Reset asserted mid-ACCESS aborts transfer; no write commits; first legal SETUP after release is served normally.

Verification
REQ-032 WAIT_CYCLES=1: write 32'hDEAD_BEEF to paddr 8'h04 -> pready high on 2nd ACCESS cycle, pslverr=0; read 8'h04 -> prdata 32'hDEAD_BEEF with pready.
REQ-033 WAIT_CYCLES=0: read paddr 8'h00 -> pready in 1st ACCESS cycle, prdata 32'hA5B2_0001; write 8'h00 -> pslverr=1, next read still 32'hA5B2_0001.
REQ-034 NUM_REGS=16: read 8'h40 and 8'h05 -> pslverr=1, prdata 32'h0; write 8'h40 -> no register changes.
REQ-035 Back-to-back write 8'h08=32'h1, read 8'h08 -> second transfer pready after WAIT_CYCLES waits, prdata 32'h1; pready never high when psel=0 or penable=0.
REQ-036 Abort: psel dropped in 1st ACCESS cycle of write 8'h0C (WAIT_CYCLES=3) -> no pready, reg 3 remains 32'h0.
REQ-037 rst_n low during wait state of write 8'h10 -> pready=0, prdata=32'h0 immediately; after release read 8'h10 -> 32'h0.

Source files
------------

// File: rtl/apb_slave_regs.sv
// APB register slave: read-only ID word at index 0 and NUM_REGS-1 read/write words,
// with a programmable number of access-phase wait states and an error response.
module apb_slave_regs #(
    parameter int WAIT_CYCLES = 1,
    parameter int NUM_REGS    = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        psel,
    input  logic        penable,
    input  logic        pwrite,
    input  logic [7:0]  paddr,
    input  logic [31:0] pwdata,
    output logic [31:0] prdata,
    output logic        pready,
    output logic        pslverr
);
    localparam logic [31:0] ID_VALUE = 32'hA5B2_0001;

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t      state;
    logic [3:0]  wait_cnt;
    logic        cap_write;
    logic        cap_err;
    logic [5:0]  cap_idx;
    logic [31:0] cap_data;
    logic [31:0] regs [1:NUM_REGS-1];

    logic [5:0]  setup_idx;
    logic        setup_err;
    logic        commit;
    logic [31:0] setup_data;

    assign setup_idx = paddr[7:2];
    assign setup_err = (paddr[1:0] != 2'b00)
                    || ({1'b0, setup_idx} >= 7'(NUM_REGS))
                    || (pwrite && (setup_idx == 6'd0));

    always_comb begin
        setup_data = 32'h0;
        if (setup_idx == 6'd0)
            setup_data = ID_VALUE;
        for (int i = 1; i < NUM_REGS; i++)
            if (setup_idx == 6'(i))
                setup_data = regs[i];
    end

    assign pready  = (state == ACCESS) && psel && penable && (wait_cnt == 4'd0);
    assign pslverr = pready && cap_err;
    assign prdata  = (pready && !cap_write && !cap_err) ? cap_data : 32'h0;
    assign commit  = pready && cap_write && !cap_err;

    // A SETUP sample always (re)starts a transfer, including a restart mid-ACCESS.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            wait_cnt  <= 4'd0;
            cap_write <= 1'b0;
            cap_err   <= 1'b0;
            cap_idx   <= 6'd0;
            cap_data  <= 32'h0;
        end else if (psel && !penable) begin
            state     <= ACCESS;
            wait_cnt  <= 4'(WAIT_CYCLES);
            cap_write <= pwrite;
            cap_err   <= setup_err;
            cap_idx   <= setup_idx;
            cap_data  <= setup_data;
        end else if (state == ACCESS) begin
            if (!psel) begin
                state    <= IDLE;
                wait_cnt <= 4'd0;
            end else if (wait_cnt != 4'd0) begin
                wait_cnt <= wait_cnt - 4'd1;
            end else begin
                state <= IDLE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i < NUM_REGS; i++)
                regs[i] <= 32'h0;
        end else if (commit) begin
            for (int i = 1; i < NUM_REGS; i++)
                if (cap_idx == 6'(i))
                    regs[i] <= pwdata;
        end
    end
endmodule

// File: tb/tb_apb_slave_regs.sv
// Three slaves (0, 1 and 3 wait states) share one APB bus and are checked against
// a register-map model; expected latency is simply WAIT_CYCLES+1 ACCESS cycles.
module tb_apb_slave_regs;
    localparam int          NUM_REGS = 16;
    localparam int          MAX_WAIT = 3;
    localparam logic [31:0] ID_VALUE = 32'hA5B2_0001;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [7:0]  paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata [3];
    logic        pready [3];
    logic        pslverr [3];

    int          wait_of [3] = '{0, 1, 3};
    logic [31:0] model [NUM_REGS];
    int          vectors = 0;
    int          miscompares = 0;

    always #5 clk = ~clk;

    apb_slave_regs #(.WAIT_CYCLES(0), .NUM_REGS(NUM_REGS)) dut0 (
        .clk(clk), .rst_n(rst_n), .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata[0]), .pready(pready[0]),
        .pslverr(pslverr[0]));

    apb_slave_regs #(.WAIT_CYCLES(1), .NUM_REGS(NUM_REGS)) dut1 (
        .clk(clk), .rst_n(rst_n), .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata[1]), .pready(pready[1]),
        .pslverr(pslverr[1]));

    apb_slave_regs #(.WAIT_CYCLES(3), .NUM_REGS(NUM_REGS)) dut3 (
        .clk(clk), .rst_n(rst_n), .psel(psel), .penable(penable), .pwrite(pwrite),
        .paddr(paddr), .pwdata(pwdata), .prdata(prdata[2]), .pready(pready[2]),
        .pslverr(pslverr[2]));

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    function automatic logic exp_err(input logic wr, input logic [7:0] addr);
        return (addr[1:0] != 2'b00) || (int'(addr[7:2]) >= NUM_REGS)
            || (wr && (addr[7:2] == 6'd0));
    endfunction

    function automatic logic [31:0] read_value(input logic [7:0] addr);
        if (addr[7:2] == 6'd0)
            return ID_VALUE;
        return model[addr[7:2]];
    endfunction

    task automatic check_quiet(input string tag);
        for (int d = 0; d < 3; d++) begin
            checkOutput($sformatf("%s dut%0d pready", tag, d), 32'(pready[d]), 32'h0);
            checkOutput($sformatf("%s dut%0d pslverr", tag, d), 32'(pslverr[d]), 32'h0);
            checkOutput($sformatf("%s dut%0d prdata", tag, d), prdata[d], 32'h0);
        end
    endtask

    task automatic bus_idle(input string tag);
        @(posedge clk); #1;
        psel    = 1'b0;
        penable = 1'b0;
        @(negedge clk);
        check_quiet(tag);
    endtask

    task automatic drive_setup(input logic wr, input logic [7:0] addr, input logic [31:0] data);
        @(posedge clk); #1;
        psel    = 1'b1;
        penable = 1'b0;
        pwrite  = wr;
        paddr   = addr;
        pwdata  = data;
    endtask

    // One full transfer; ACCESS is held until the slowest slave has answered.
    task automatic applyStimulus(input string tag, input logic wr, input logic [7:0] addr,
                                 input logic [31:0] data, input logic scramble);
        logic        err;
        logic [31:0] rd;
        logic        rdy;
        err = exp_err(wr, addr);
        rd  = (wr || err) ? 32'h0 : read_value(addr);
        drive_setup(wr, addr, data);
        @(negedge clk);
        check_quiet({tag, " setup"});
        for (int k = 1; k <= MAX_WAIT + 1; k++) begin
            @(posedge clk); #1;
            penable = 1'b1;
            if (scramble) begin
                paddr  = 8'($urandom);
                pwrite = 1'($urandom);
            end
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                rdy = (k == wait_of[d] + 1);
                checkOutput($sformatf("%s c%0d dut%0d pready", tag, k, d), 32'(pready[d]), 32'(rdy));
                checkOutput($sformatf("%s c%0d dut%0d pslverr", tag, k, d), 32'(pslverr[d]),
                            32'(rdy && err));
                checkOutput($sformatf("%s c%0d dut%0d prdata", tag, k, d), prdata[d],
                            rdy ? rd : 32'h0);
            end
        end
        if (wr && !err)
            model[addr[7:2]] = data;
    endtask

    task automatic read_all(input string tag);
        for (int i = 0; i < NUM_REGS; i++)
            applyStimulus($sformatf("%s r%0d", tag, i), 1'b0, 8'(i * 4), 32'h0, 1'b0);
    endtask

    initial begin
        logic [7:0] addr;
        rst_n   = 1'b0;
        psel    = 1'b0;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = 8'h00;
        pwdata  = 32'h0;
        for (int i = 0; i < NUM_REGS; i++)
            model[i] = 32'h0;
        #2;
        check_quiet("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        applyStimulus("wr04", 1'b1, 8'h04, 32'hDEAD_BEEF, 1'b0);
        applyStimulus("rd04", 1'b0, 8'h04, 32'h0, 1'b0);
        applyStimulus("rd00", 1'b0, 8'h00, 32'h0, 1'b0);
        applyStimulus("wr00", 1'b1, 8'h00, 32'h1234_5678, 1'b0);
        applyStimulus("rd00b", 1'b0, 8'h00, 32'h0, 1'b0);
        applyStimulus("rd40", 1'b0, 8'h40, 32'h0, 1'b0);
        applyStimulus("rd05", 1'b0, 8'h05, 32'h0, 1'b0);
        applyStimulus("wr40", 1'b1, 8'h40, 32'hFFFF_FFFF, 1'b0);
        read_all("map1");

        applyStimulus("b2b wr08", 1'b1, 8'h08, 32'h1, 1'b0);
        applyStimulus("b2b rd08", 1'b0, 8'h08, 32'h0, 1'b0);
        bus_idle("idle1");

        // Abort: psel dropped in the first ACCESS cycle.
        drive_setup(1'b1, 8'h0C, 32'hCAFE_F00D);
        @(negedge clk);
        check_quiet("abort setup");
        @(posedge clk); #1;
        psel = 1'b0;
        @(negedge clk);
        check_quiet("abort access");
        bus_idle("abort idle");
        applyStimulus("rd0c", 1'b0, 8'h0C, 32'h0, 1'b0);

        // Requester restarts SETUP mid-transfer; the first write must vanish.
        drive_setup(1'b1, 8'h18, 32'h5555_AAAA);
        applyStimulus("restart rd08", 1'b0, 8'h08, 32'h0, 1'b0);
        applyStimulus("rd18", 1'b0, 8'h18, 32'h0, 1'b0);
        bus_idle("idle2");

        // penable without a preceding SETUP is ignored.
        @(posedge clk); #1;
        psel    = 1'b1;
        penable = 1'b1;
        pwrite  = 1'b1;
        paddr   = 8'h14;
        pwdata  = 32'h7777_7777;
        repeat (2) begin
            @(negedge clk);
            check_quiet("nosetup");
        end
        bus_idle("idle3");
        applyStimulus("rd14", 1'b0, 8'h14, 32'h0, 1'b0);

        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 5) == 0)
                addr = 8'($urandom);
            else
                addr = 8'($urandom_range(0, NUM_REGS - 1) * 4);
            applyStimulus($sformatf("rand%0d", n), 1'($urandom), addr, $urandom, 1'b1);
            if ($urandom_range(0, 7) == 0)
                bus_idle($sformatf("rand idle%0d", n));
        end
        read_all("map2");

        // Reset during the wait state of a write.
        applyStimulus("pre wr04", 1'b1, 8'h04, 32'h0BAD_F00D, 1'b0);
        drive_setup(1'b1, 8'h10, 32'h1357_9BDF);
        @(posedge clk); #1;
        penable = 1'b1;
        @(negedge clk); #1;
        rst_n = 1'b0;
        #1;
        check_quiet("rst mid");
        psel    = 1'b0;
        penable = 1'b0;
        for (int i = 0; i < NUM_REGS; i++)
            model[i] = 32'h0;
        @(negedge clk); #2;
        rst_n = 1'b1;
        bus_idle("post rst");
        applyStimulus("rd10", 1'b0, 8'h10, 32'h0, 1'b0);
        applyStimulus("rd04 post", 1'b0, 8'h04, 32'h0, 1'b0);
        bus_idle("end");

        $display("[TB] == %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
